// File: rtl/stdp_grad_gen_if.sv
// rtl/stdp_grad_gen_if.sv - gradient beat stream from stdp_grad_gen to the weight optimizer
interface stdp_grad_gen_if #(
   parameter int N_SYN = 8
);
   localparam int IW = $clog2(N_SYN);

   logic              grad_valid;
   logic              grad_ready;
   logic [IW-1:0]     grad_idx;
   logic signed [7:0] grad_out;
   logic              grad_spike;

   modport master (output grad_valid, grad_idx, grad_out, grad_spike, input grad_ready);
   modport slave  (input grad_valid, grad_idx, grad_out, grad_spike, output grad_ready);
endinterface

// File: rtl/stdp_grad_gen.sv
// rtl/stdp_grad_gen.sv - STDP trace-based gradient generator streaming one gradient per synapse per tick
// Optional macro GRAD_ZERO_SKIP_EN: emit only nonzero gradients.
module stdp_grad_gen #(
   parameter int N_SYN       = 8,
   parameter int TRACE_W     = 8,
   parameter int TRACE_INC   = 64,
   parameter int DECAY_SHIFT = 2,
   parameter int GRAD_SHIFT  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic [N_SYN-1:0]   pre_spike,
   input  logic               post_spike,
   stdp_grad_gen_if.master    gr,
   output logic               busy,
   output logic               done,
   output logic               overrun
);
   localparam int IW = $clog2(N_SYN);
   localparam int SW = TRACE_W + 2;
   localparam logic signed [SW-1:0] G_MAX = SW'(127);
   localparam logic signed [SW-1:0] G_MIN = SW'(-128);
   localparam logic [SW-1:0]        T_MAX = SW'((1 << TRACE_W) - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_UPDATE} state_t;

   state_t               state_q, state_d;
   logic [N_SYN-1:0]     sp_pre_q, sp_pre_d;
   logic                 sp_post_q, sp_post_d;
   logic [TRACE_W-1:0]   pre_trace_q [N_SYN];
   logic [TRACE_W-1:0]   pre_trace_d [N_SYN];
   logic [TRACE_W-1:0]   post_trace_q, post_trace_d;
   logic                 grad_valid_q, grad_valid_d;
   logic [IW-1:0]        grad_idx_q, grad_idx_d;
   logic signed [7:0]    grad_out_q, grad_out_d;
   logic                 grad_spike_q, grad_spike_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 overrun_q, overrun_d;

   logic [N_SYN-1:0]     sel_pre;
   logic                 sel_post;
   logic signed [SW-1:0] diff;
   logic signed [7:0]    grad_all [N_SYN];
   logic [N_SYN-1:0]     grad_nz;
   logic [IW:0]          scan_start;
   logic                 nxt_found;
   logic [IW-1:0]        nxt_idx;

   function automatic logic [TRACE_W-1:0] decay_inc(input logic [TRACE_W-1:0] t, input logic s);
      logic [SW-1:0] n;
      n = {2'b00, t} - {2'b00, t >> DECAY_SHIFT} + (s ? SW'(TRACE_INC) : SW'(0));
      return (n > T_MAX) ? T_MAX[TRACE_W-1:0] : n[TRACE_W-1:0];
   endfunction

   // In IDLE the first beat is computed from the live spike inputs, since the latch happens on the same edge.
   always_comb begin
      sel_pre  = (state_q == S_IDLE) ? pre_spike : sp_pre_q;
      sel_post = (state_q == S_IDLE) ? post_spike : sp_post_q;
      grad_all = '{default: '0};
      grad_nz  = '0;
      diff     = '0;
      for (int i = 0; i < N_SYN; i++) begin
         diff = (sel_pre[i] ? {2'b00, post_trace_q >> GRAD_SHIFT} : '0)
              - (sel_post ? {2'b00, pre_trace_q[i] >> GRAD_SHIFT} : '0);
         if (diff > G_MAX)      grad_all[i] = 8'h7F;
         else if (diff < G_MIN) grad_all[i] = 8'h80;
         else                   grad_all[i] = diff[7:0];
         grad_nz[i] = (grad_all[i] != '0);
      end
   end

   always_comb begin
      scan_start = (state_q == S_IDLE) ? '0 : ({1'b0, grad_idx_q} + (IW+1)'(1));
      nxt_found  = 1'b0;
      nxt_idx    = '0;
`ifdef GRAD_ZERO_SKIP_EN
      for (int i = N_SYN - 1; i >= 0; i--) begin
         if (((IW+1)'(i) >= scan_start) && grad_nz[i]) begin
            nxt_found = 1'b1;
            nxt_idx   = IW'(i);
         end
      end
`else
      nxt_found = (scan_start < (IW+1)'(N_SYN));
      nxt_idx   = scan_start[IW-1:0];
`endif
   end

   always_comb begin
      state_d      = state_q;
      sp_pre_d     = sp_pre_q;
      sp_post_d    = sp_post_q;
      pre_trace_d  = pre_trace_q;
      post_trace_d = post_trace_q;
      grad_valid_d = grad_valid_q;
      grad_idx_d   = grad_idx_q;
      grad_out_d   = grad_out_q;
      grad_spike_d = grad_spike_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      overrun_d    = overrun_q | (tick && (state_q != S_IDLE));
      unique case (state_q)
         S_IDLE: begin
            if (tick) begin
               sp_pre_d  = pre_spike;
               sp_post_d = post_spike;
               busy_d    = 1'b1;
               if ((pre_spike == '0) && !post_spike) begin
                  state_d = S_UPDATE;
                  done_d  = 1'b1;
               end else begin
                  state_d      = S_SCAN;
                  grad_valid_d = nxt_found;
                  grad_idx_d   = nxt_idx;
                  grad_out_d   = grad_all[nxt_idx];
                  grad_spike_d = grad_nz[nxt_idx];
               end
            end
         end
         S_SCAN: begin
            if (!grad_valid_q || gr.grad_ready) begin
               if (grad_valid_q && nxt_found) begin
                  grad_idx_d   = nxt_idx;
                  grad_out_d   = grad_all[nxt_idx];
                  grad_spike_d = grad_nz[nxt_idx];
               end else begin
                  state_d      = S_UPDATE;
                  done_d       = 1'b1;
                  grad_valid_d = 1'b0;
                  grad_out_d   = '0;
                  grad_spike_d = 1'b0;
               end
            end
         end
         S_UPDATE: begin
            for (int i = 0; i < N_SYN; i++)
               pre_trace_d[i] = decay_inc(pre_trace_q[i], sp_pre_q[i]);
            post_trace_d = decay_inc(post_trace_q, sp_post_q);
            state_d      = S_IDLE;
            busy_d       = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sp_pre_q     <= '0;
         sp_post_q    <= 1'b0;
         for (int i = 0; i < N_SYN; i++) pre_trace_q[i] <= '0;
         post_trace_q <= '0;
         grad_valid_q <= 1'b0;
         grad_idx_q   <= '0;
         grad_out_q   <= '0;
         grad_spike_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sp_pre_q     <= sp_pre_d;
         sp_post_q    <= sp_post_d;
         pre_trace_q  <= pre_trace_d;
         post_trace_q <= post_trace_d;
         grad_valid_q <= grad_valid_d;
         grad_idx_q   <= grad_idx_d;
         grad_out_q   <= grad_out_d;
         grad_spike_q <= grad_spike_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign gr.grad_valid = grad_valid_q;
   assign gr.grad_idx   = grad_idx_q;
   assign gr.grad_out   = grad_out_q;
   assign gr.grad_spike = grad_spike_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign overrun       = overrun_q;
endmodule

// File: tb/tb_stdp_grad_gen.sv
// tb/tb_stdp_grad_gen.sv - directed and randomized self-checking bench for stdp_grad_gen
module tb_stdp_grad_gen;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic [N-1:0] pre_spike = '0;
   logic         post_spike = 1'b0;
   logic         busy, done, overrun;

   stdp_grad_gen_if #(.N_SYN(N)) gif ();

   stdp_grad_gen #(.N_SYN(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .gr         (gif),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int pre_tr [N];
   int post_tr = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int trace_next(input int t, input bit s);
      int n;
      n = t - t / 4 + (s ? 64 : 0);
      return (n > 255) ? 255 : n;
   endfunction

   // One time step: tick, drain the beats (optionally stalling at one index), check done, advance the model.
   task automatic do_step(input logic [N-1:0] pre, input logic post, input int stall_at);
      int exp_g [N];
      int g;
      for (int i = 0; i < N; i++) begin
         g = (pre[i] ? post_tr / 8 : 0) - (post ? pre_tr[i] / 8 : 0);
         exp_g[i] = (g > 127) ? 127 : (g < -128) ? -128 : g;
      end
      tick = 1'b1; pre_spike = pre; post_spike = post;
      @(posedge clk); #1;
      tick = 1'b0; pre_spike = N'($urandom); post_spike = 1'($urandom);
      if (pre == '0 && !post) begin
         chk("nospike_done", done, 1);
         chk("nospike_busy", busy, 1);
         chk("nospike_valid", gif.grad_valid, 0);
      end else begin
         for (int k = 0; k < N; k++) begin
            chk("beat_valid", gif.grad_valid, 1);
            chk("beat_idx", gif.grad_idx, k);
            chk("beat_grad", gif.grad_out, exp_g[k]);
            chk("beat_spike", gif.grad_spike, exp_g[k] != 0);
            if (k == stall_at) begin
               gif.grad_ready = 1'b0;
               for (int c = 0; c < 5; c++) begin
                  tick = (c == 0);
                  @(posedge clk); #1;
                  tick = 1'b0;
                  chk("stall_valid", gif.grad_valid, 1);
                  chk("stall_idx", gif.grad_idx, k);
                  chk("stall_grad", gif.grad_out, exp_g[k]);
                  chk("stall_busy", busy, 1);
               end
               gif.grad_ready = 1'b1;
            end
            @(posedge clk); #1;
         end
         chk("scan_done", done, 1);
         chk("scan_end_busy", busy, 1);
         chk("scan_end_valid", gif.grad_valid, 0);
      end
      pre_spike = '0; post_spike = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      for (int i = 0; i < N; i++) pre_tr[i] = trace_next(pre_tr[i], pre[i]);
      post_tr = trace_next(post_tr, post);
   endtask

   initial begin
      for (int i = 0; i < N; i++) pre_tr[i] = 0;
      gif.grad_ready = 1'b1;
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         tick = ~tick; pre_spike = 8'hFF; post_spike = 1'b1;
      end
      @(posedge clk); #1;
      chk("rst_valid", gif.grad_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_step(8'h01, 1'b0, -1);
      do_step(8'h00, 1'b1, -1);
      do_step(8'h02, 1'b0, -1);
      chk("overrun_before", overrun, 0);
      do_step(8'h5A, 1'b1, 3);
      chk("overrun_set", overrun, 1);
      do_step(8'h00, 1'b0, -1);

      for (int s = 0; s < 20; s++) do_step(8'h02, 1'b0, -1);
      do_step(8'h00, 1'b1, -1);
      chk("sat_overrun_sticky", overrun, 1);

      for (int s = 0; s < 10; s++) begin
         logic [N-1:0] p;
         p = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         do_step(p, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
      end

      tick = 1'b1; pre_spike = 8'hFF; post_spike = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_idx", gif.grad_idx, 4);
      chk("mid_valid", gif.grad_valid, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", gif.grad_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_overrun", overrun, 0);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) pre_tr[i] = 0;
      post_tr = 0;
      @(posedge clk); #1;
      do_step(8'hFF, 1'b1, -1);
      do_step(8'h10, 1'b0, -1);
      do_step(8'h00, 1'b1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
